bridge_sequencer: RTL and testbench
===================================

BRIDGE_SEQUENCER -- requirements
Module: bridge_sequencer

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 16, which sets the width of the count and configuration fields.
REQ-002 The block SHALL have parameter DT_RESET, default 10, which is the dead-time count loaded at reset.
REQ-003 MClk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 RstN  input  1  asynchronous, active-low reset.
REQ-005 Enable  input  1  run request; level-sensitive.
REQ-006 FaultN  input  1  bridge fault, active-low.
REQ-007 FaultClr  input  1  single-cycle pulse that clears a latched fault.
REQ-008 PeriodStart  input  1  single-cycle pulse marking a PWM period boundary.
REQ-009 PwmIn  input  1  raw PWM from the duty comparator.
REQ-010 PrechargeCount  input  BIT_WIDTH  bootstrap-precharge length in cycles.
REQ-011 CfgDeadTime  input  BIT_WIDTH  requested dead-time count.
REQ-012 CfgValid  input  1  CfgDeadTime is valid.
REQ-013 CfgReady  output  1  block can accept a configuration.
REQ-014 SPDT  output  2  bridge command to the dead-time stage; bit 1 is the high side, bit 0 is the low side.
REQ-015 DeadTimeCount  output  BIT_WIDTH  active dead-time count sent to the dead-time stage.
REQ-016 State  output  2  encoding: IDLE=00, PRECHARGE=01, RUN=10, FAULT=11.
REQ-017 Running  output  1  high exactly while State=RUN.

Function
REQ-018 The FSM SHALL operate as follows in IDLE:
- SPDT=00.
- If Enable=1 and no fault is present, go to PRECHARGE next cycle.
- Clear the precharge counter.
REQ-019 The FSM SHALL operate as follows in PRECHARGE:
- SPDT=01 (low side on).
- Increment the counter every cycle, saturating at PrechargeCount.
- Go to RUN on the first PeriodStart seen with counter==PrechargeCount.
- With PrechargeCount=0, go to RUN on the first PeriodStart.
REQ-020 The FSM SHALL operate as follows in RUN:
- SPDT={PwmIn, ~PwmIn}, registered, giving 1 cycle of latency from PwmIn.
REQ-021 If Enable=0 in PRECHARGE or RUN, the FSM SHALL go to IDLE next cycle and set SPDT=00 at that edge.
REQ-022 The FSM SHALL operate as follows in FAULT:
- SPDT=00, latched.
- Exit to IDLE only when FaultClr=1 and the (sampled) fault has been inactive during that same cycle.
- Ignore Enable while in FAULT.
REQ-023 A fault seen in any non-FAULT state SHALL force FAULT next cycle, with priority over Enable, PeriodStart and counter completion.
REQ-024 SPDT SHALL never equal 11 in any cycle.
REQ-025 The configuration handshake SHALL work as follows:
- A transfer occurs when CfgValid and CfgReady are both 1 on a rising edge.
- A transfer captures CfgDeadTime into a pending register and drives CfgReady to 0 next cycle.
REQ-026 The pending value SHALL commit to DeadTimeCount as follows:
- In RUN and PRECHARGE, commit on the next PeriodStart that occurs strictly after the accepting edge.
- In IDLE and FAULT, commit on the cycle after acceptance.
- CfgReady SHALL return to 1 on the cycle after the commit.
REQ-027 If a transfer and PeriodStart occur in the same cycle, the new value SHALL wait for the following PeriodStart.
REQ-028 DeadTimeCount SHALL change only at a commit; a dead time of 0 SHALL be passed through unmodified.
REQ-029 A pending value SHALL survive state changes, including entry to FAULT, and SHALL commit under the rule of the state it is in at the time.

Reset
REQ-030 While RstN=0, the block SHALL immediately drive:
- State=IDLE, SPDT=00, Running=0, CfgReady=0.
- DeadTimeCount=DT_RESET.
- Precharge counter=0, pending register empty.
REQ-031 CfgReady SHALL rise on the first MClk edge after RstN deasserts.
REQ-032 Reset asserted mid-RUN or mid-handshake SHALL discard any pending configuration.

Configuration
REQ-033 With BRIDGE_SEQ_FAULT_SYNC_EN defined, FaultN SHALL pass through a 2-flop synchronizer (reset value 1), and fault-to-FAULT latency SHALL be 3 cycles.
REQ-034 Without BRIDGE_SEQ_FAULT_SYNC_EN, FaultN SHALL be sampled directly, and fault-to-FAULT latency SHALL be 1 cycle.

Verification
REQ-035 Startup: reset, PrechargeCount=5, Enable=1, PeriodStart every 20 cycles -> SPDT=01 for at least 5 cycles, then RUN at the first qualifying PeriodStart, then SPDT tracks {PwmIn,~PwmIn} 1 cycle late.
REQ-036 Config during RUN: CfgDeadTime=25 accepted mid-period -> DeadTimeCount stays 10 until the next PeriodStart, then becomes 25; CfgReady is 0 throughout the wait.
REQ-037 Simultaneous accept and PeriodStart: CfgDeadTime=7 accepted in the same cycle as PeriodStart -> DeadTimeCount becomes 7 only at the following PeriodStart.
REQ-038 Fault in RUN: pulse FaultN=0 for 1 cycle -> State=11 and SPDT=00 after 1 cycle (3 cycles with the macro); Enable toggling has no effect; FaultClr with FaultN=1 -> IDLE.
REQ-039 Abort: Enable drops during PRECHARGE at count 3 -> IDLE next cycle with SPDT=00; re-enable restarts the count from 0.
REQ-040 Async reset mid-handshake: RstN low between clock edges -> outputs reach reset values without a clock edge; the pending value is lost and DeadTimeCount=10.

Source files
------------

// File: rtl/bridge_sequencer.sv
// H-bridge start-up sequencer: IDLE -> bootstrap PRECHARGE -> RUN, latched FAULT, plus a
// dead-time configuration handshake. Define BRIDGE_SEQ_FAULT_SYNC_EN to add a 2-flop FaultN synchronizer.
module bridge_sequencer #(
   parameter int BIT_WIDTH = 16,
   parameter int DT_RESET  = 10
) (
   input  logic                 MClk,
   input  logic                 RstN,
   input  logic                 Enable,
   input  logic                 FaultN,
   input  logic                 FaultClr,
   input  logic                 PeriodStart,
   input  logic                 PwmIn,
   input  logic [BIT_WIDTH-1:0] PrechargeCount,
   input  logic [BIT_WIDTH-1:0] CfgDeadTime,
   input  logic                 CfgValid,
   output logic                 CfgReady,
   output logic [1:0]           SPDT,
   output logic [BIT_WIDTH-1:0] DeadTimeCount,
   output logic [1:0]           State,
   output logic                 Running
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_PRE   = 2'b01;
   localparam logic [1:0] ST_RUN   = 2'b10;
   localparam logic [1:0] ST_FAULT = 2'b11;

   localparam logic [BIT_WIDTH-1:0] DT_INIT = BIT_WIDTH'(DT_RESET);
   localparam logic [BIT_WIDTH-1:0] CNT_ONE = BIT_WIDTH'(1);

   logic fault;

`ifdef BRIDGE_SEQ_FAULT_SYNC_EN
   logic faultn_p0;
   logic faultn_p1;

   // Two-stage synchronizer; idles at 1 so reset never looks like a fault.
   always_ff @(posedge MClk or negedge RstN) begin
      if (!RstN) begin
         faultn_p0 <= 1'b1;
         faultn_p1 <= 1'b1;
      end else begin
         faultn_p0 <= FaultN;
         faultn_p1 <= faultn_p0;
      end
   end

   assign fault = ~faultn_p1;
`else
   assign fault = ~FaultN;
`endif

   logic [1:0]           state_q;
   logic [1:0]           state_d;
   logic [BIT_WIDTH-1:0] pre_cnt_q;
   logic [BIT_WIDTH-1:0] pre_cnt_d;
   logic [1:0]           spdt_q;
   logic [1:0]           spdt_d;
   logic                 pre_done;

   assign pre_done = (pre_cnt_q >= PrechargeCount);

   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      case (state_q)
         ST_IDLE: begin
            pre_cnt_d = '0;
            if (fault)       state_d = ST_FAULT;
            else if (Enable) state_d = ST_PRE;
         end
         ST_PRE: begin
            if (fault)                          state_d = ST_FAULT;
            else if (!Enable)                   state_d = ST_IDLE;
            else if (PeriodStart && pre_done)   state_d = ST_RUN;
            else if (!pre_done)                 pre_cnt_d = pre_cnt_q + CNT_ONE;
         end
         ST_RUN: begin
            if (fault)        state_d = ST_FAULT;
            else if (!Enable) state_d = ST_IDLE;
         end
         default: begin
            if (FaultClr && !fault) state_d = ST_IDLE;
         end
      endcase
   end

   // Drive SPDT from the next state so it changes on the same edge as State; 11 is unreachable.
   always_comb begin
      case (state_d)
         ST_PRE:  spdt_d = 2'b01;
         ST_RUN:  spdt_d = {PwmIn, ~PwmIn};
         default: spdt_d = 2'b00;
      endcase
   end

   always_ff @(posedge MClk or negedge RstN) begin
      if (!RstN) begin
         state_q   <= ST_IDLE;
         pre_cnt_q <= '0;
         spdt_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         spdt_q    <= spdt_d;
      end
   end

   logic                 pend_vld;
   logic [BIT_WIDTH-1:0] pend_val;
   logic                 cfg_ready_q;
   logic [BIT_WIDTH-1:0] dt_cnt_q;
   logic                 accept;
   logic                 commit;

   assign accept = CfgValid & cfg_ready_q;
   // Pending is only set after the accepting edge, so a same-cycle PeriodStart cannot commit it.
   assign commit = pend_vld & (((state_q == ST_PRE) || (state_q == ST_RUN)) ? PeriodStart : 1'b1);

   always_ff @(posedge MClk or negedge RstN) begin
      if (!RstN) begin
         pend_vld    <= 1'b0;
         cfg_ready_q <= 1'b0;
         dt_cnt_q    <= DT_INIT;
      end else begin
         if (accept)      pend_vld <= 1'b1;
         else if (commit) pend_vld <= 1'b0;
         if (commit)      dt_cnt_q <= pend_val;
         cfg_ready_q <= ~accept & ~pend_vld;
      end
   end

   always_ff @(posedge MClk) begin
      if (accept) pend_val <= CfgDeadTime;
   end

   assign CfgReady      = cfg_ready_q;
   assign SPDT          = spdt_q;
   assign DeadTimeCount = dt_cnt_q;
   assign State         = state_q;
   assign Running       = (state_q == ST_RUN);

endmodule

// File: tb/tb_bridge_sequencer.sv
// Scoreboard bench for bridge_sequencer: directed scenarios followed by randomized traffic,
// checked each cycle against a behavioural model of the sequencer rules.
module tb_bridge_sequencer;
   localparam int W   = 16;
   localparam int DTR = 10;
   localparam int M_IDLE = 0, M_PRE = 1, M_RUN = 2, M_FLT = 3;

   logic         MClk = 1'b0;
   logic         RstN = 1'b0;
   logic         Enable = 1'b0, FaultN = 1'b1, FaultClr = 1'b0, PeriodStart = 1'b0;
   logic         PwmIn = 1'b0, CfgValid = 1'b0;
   logic [W-1:0] PrechargeCount = '0;
   logic [W-1:0] CfgDeadTime = '0;
   logic         CfgReady, Running;
   logic [1:0]   SPDT, State;
   logic [W-1:0] DeadTimeCount;

   bridge_sequencer #(.BIT_WIDTH(W), .DT_RESET(DTR)) dut (
      .MClk(MClk), .RstN(RstN), .Enable(Enable), .FaultN(FaultN), .FaultClr(FaultClr),
      .PeriodStart(PeriodStart), .PwmIn(PwmIn), .PrechargeCount(PrechargeCount),
      .CfgDeadTime(CfgDeadTime), .CfgValid(CfgValid), .CfgReady(CfgReady), .SPDT(SPDT),
      .DeadTimeCount(DeadTimeCount), .State(State), .Running(Running)
   );

   always #5 MClk = ~MClk;

   typedef struct {
      logic [1:0]   st;
      logic [1:0]   spdt;
      logic         run;
      logic         rdy;
      logic [W-1:0] dt;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural model state
   int m_mode, m_pre_cycles, m_dt, m_pendval;
   bit m_pend, m_rdy, fh0, fh1;
   logic [1:0] m_spdt;

   int pcyc = 1, plen = 20;
   logic [W-1:0] pc_cfg = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode = M_IDLE; m_pre_cycles = 0; m_spdt = 2'b00; m_dt = DTR;
      m_pend = 1'b0; m_pendval = 0; m_rdy = 1'b0; fh0 = 1'b1; fh1 = 1'b1;
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   function automatic void model_step();
      bit flt, commit, accept, was_pend;
`ifdef BRIDGE_SEQ_FAULT_SYNC_EN
      flt = !fh1; fh1 = fh0; fh0 = FaultN;
`else
      flt = !FaultN;
`endif
      was_pend = m_pend;
      commit = m_pend && ((m_mode == M_IDLE || m_mode == M_FLT) || PeriodStart);
      accept = CfgValid && m_rdy;
      if (commit) begin m_dt = m_pendval; m_pend = 1'b0; end
      if (accept) begin m_pendval = int'(CfgDeadTime); m_pend = 1'b1; end
      m_rdy = !accept && !was_pend;
      case (m_mode)
         M_IDLE: begin
            m_pre_cycles = 0;
            if (flt) m_mode = M_FLT;
            else if (Enable) m_mode = M_PRE;
         end
         M_PRE: begin
            if (flt) m_mode = M_FLT;
            else if (!Enable) m_mode = M_IDLE;
            else if (PeriodStart && m_pre_cycles >= int'(PrechargeCount)) m_mode = M_RUN;
            else m_pre_cycles++;
         end
         M_RUN: begin
            if (flt) m_mode = M_FLT;
            else if (!Enable) m_mode = M_IDLE;
         end
         default: if (FaultClr && !flt) m_mode = M_IDLE;
      endcase
      m_spdt = (m_mode == M_PRE) ? 2'b01 : (m_mode == M_RUN) ? {PwmIn, !PwmIn} : 2'b00;
   endfunction

   task automatic push_exp();
      exp_t e;
      e.st = 2'(m_mode); e.spdt = m_spdt; e.run = (m_mode == M_RUN);
      e.rdy = m_rdy; e.dt = W'(m_dt);
      sbq.push_back(e);
   endtask

   task automatic drive(input bit en, input bit fn, input bit fc, input bit ps, input bit pwm,
                        input bit cv, input logic [W-1:0] cdt);
      @(negedge MClk);
      Enable = en; FaultN = fn; FaultClr = fc; PeriodStart = ps; PwmIn = pwm;
      CfgValid = cv; CfgDeadTime = cdt; PrechargeCount = pc_cfg;
      model_step();
      push_exp();
   endtask

   task automatic step_auto(input bit en, input bit fn, input bit fc, input bit cv,
                            input logic [W-1:0] cdt);
      bit ps;
      ps = ((pcyc % plen) == 0);
      pcyc++;
      drive(en, fn, fc, ps, 1'($urandom % 2), cv, cdt);
   endtask

   task automatic run_idle(input int n, input bit en);
      for (int i = 0; i < n; i++) step_auto(en, 1'b1, 1'b0, 1'b0, '0);
   endtask

   // Reset is asserted between edges, once the scoreboard queue has drained.
   task automatic do_reset();
      @(negedge MClk);
      #1;
      RstN = 1'b0;
      #1;
      chk("rst_state", State, 0);
      chk("rst_spdt", SPDT, 0);
      chk("rst_running", Running, 0);
      chk("rst_cfgready", CfgReady, 0);
      chk("rst_deadtime", DeadTimeCount, DTR);
      model_reset();
      Enable = 1'b0; FaultN = 1'b1; FaultClr = 1'b0; PeriodStart = 1'b0; CfgValid = 1'b0;
      PrechargeCount = pc_cfg;
      repeat (3) @(negedge MClk);
      RstN = 1'b1;
      model_step();
      push_exp();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge MClk);
         #2;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("State", State, e.st);
            chk("SPDT", SPDT, e.spdt);
            chk("Running", Running, e.run);
            chk("CfgReady", CfgReady, e.rdy);
            chk("DeadTimeCount", DeadTimeCount, e.dt);
            chk("SPDT_not_11", (SPDT == 2'b11), 0);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got %0t expected below 2000000", $time);
      $fatal(1);
   end

   initial begin : stim
      bit en_r;
      model_reset();
      pc_cfg = 16'd5;
      do_reset();
      // Startup through precharge into run
      pcyc = 1; plen = 20;
      run_idle(50, 1'b1);
      // Config accepted mid-period while running
      while ((pcyc % plen) != 8) run_idle(1, 1'b1);
      step_auto(1'b1, 1'b1, 1'b0, 1'b1, 16'd25);
      run_idle(30, 1'b1);
      // Config accepted in the same cycle as PeriodStart
      while ((pcyc % plen) != 0) run_idle(1, 1'b1);
      step_auto(1'b1, 1'b1, 1'b0, 1'b1, 16'd7);
      run_idle(45, 1'b1);
      // One-cycle fault pulse in run, Enable toggling, then clear
      step_auto(1'b1, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 6; i++) step_auto(1'(i % 2), 1'b1, 1'b0, 1'b0, '0);
      step_auto(1'b1, 1'b1, 1'b1, 1'b0, '0);
      run_idle(4, 1'b0);
      // Abort during precharge, then restart
      run_idle(4, 1'b1);
      run_idle(2, 1'b0);
      run_idle(45, 1'b1);
      // Reset while a configuration is pending
      while ((pcyc % plen) != 5) run_idle(1, 1'b1);
      step_auto(1'b1, 1'b1, 1'b0, 1'b1, 16'd99);
      run_idle(2, 1'b1);
      do_reset();
      // Zero-length precharge and zero dead time
      pc_cfg = '0;
      run_idle(3, 1'b0);
      step_auto(1'b0, 1'b1, 1'b0, 1'b1, 16'd0);
      run_idle(45, 1'b1);
      // Randomized traffic
      en_r = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         if (($urandom % 100) < 3) en_r = !en_r;
         if (m_mode == M_IDLE && ($urandom % 10) == 0) pc_cfg = W'($urandom % 8);
         if (($urandom % 1000) < 3) begin
            do_reset();
         end else begin
            drive(en_r, !(($urandom % 100) < 2), (($urandom % 100) < 10), (($urandom % 100) < 6),
                  1'($urandom % 2), (($urandom % 100) < 30),
                  (($urandom % 4) == 0) ? W'(0) : W'($urandom % 200));
         end
      end
      run_idle(3, 1'b0);
      repeat (3) @(posedge MClk);
      #5;
      chk("scoreboard_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
